// File: rtl/rot_scheduler_if.sv
// Request/response bundle for the two-port rotate scheduler.
// The master side drives requests and consumes responses; the slave side is the scheduler.
interface rot_scheduler_if;
   logic        req_valid_0;
   logic        req_valid_1;
   logic        req_ready_0;
   logic        req_ready_1;
   logic        req_dir_0;
   logic        req_dir_1;
   logic [31:0] req_amt_0;
   logic [31:0] req_amt_1;
   logic [31:0] req_data_0;
   logic [31:0] req_data_1;
   logic        rsp_valid_0;
   logic        rsp_valid_1;
   logic        rsp_ready_0;
   logic        rsp_ready_1;
   logic [31:0] rsp_data_0;
   logic [31:0] rsp_data_1;

   modport master (
      output req_valid_0, req_valid_1, req_dir_0, req_dir_1,
             req_amt_0, req_amt_1, req_data_0, req_data_1,
             rsp_ready_0, rsp_ready_1,
      input  req_ready_0, req_ready_1,
             rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1
   );

   modport slave (
      input  req_valid_0, req_valid_1, req_dir_0, req_dir_1,
             req_amt_0, req_amt_1, req_data_0, req_data_1,
             rsp_ready_0, rsp_ready_1,
      output req_ready_0, req_ready_1,
             rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1
   );
endinterface

// File: rtl/rot_scheduler.sv
// Two-port round-robin scheduler in front of one shared 32-bit rotate unit.
// One operation in flight: accept (IDLE) -> compute (EXEC) -> hold result (RESP).
module rot_scheduler #(
   parameter bit RR_INIT = 1'b0
) (
   input  logic            clock,
   input  logic            clear,
   rot_scheduler_if.slave  bus,
   output logic            busy,
   output logic            grant_id
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        rr_ptr;
   logic        op_dir;
   logic [4:0]  op_amt;
   logic [31:0] op_data;
   logic        op_grant;
   logic [31:0] result;
   logic [31:0] rot_out;
   logic [4:0]  rot_left_amt;
   logic        accept_0;
   logic        accept_1;
   logic        rsp_done;
   logic        amt_hi_unused;

   // Only amt mod 32 participates in the rotate.
   assign amt_hi_unused = ^{bus.req_amt_0[31:5], bus.req_amt_1[31:5]};

   // Five-stage log rotator, left only; right rotates become left by (32-N) mod 32.
   function automatic logic [31:0] rotl32(input logic [31:0] d, input logic [4:0] n);
      logic [31:0] s;
      s = d;
      if (n[0]) s = {s[30:0], s[31]};
      if (n[1]) s = {s[29:0], s[31:30]};
      if (n[2]) s = {s[27:0], s[31:28]};
      if (n[3]) s = {s[23:0], s[31:24]};
      if (n[4]) s = {s[15:0], s[31:16]};
      return s;
   endfunction

   always_comb begin
      rot_left_amt = op_dir ? (5'd0 - op_amt) : op_amt;
      rot_out      = rotl32(op_data, rot_left_amt);
   end

   // Arbitration: contention is settled by the pointer, a lone requester always wins.
   always_comb begin
      accept_0 = 1'b0;
      accept_1 = 1'b0;
      if (clear && (state == IDLE)) begin
         accept_0 = bus.req_valid_0 && (!bus.req_valid_1 || (rr_ptr == 1'b0));
         accept_1 = bus.req_valid_1 && (!bus.req_valid_0 || (rr_ptr == 1'b1));
      end
   end

   always_comb begin
      rsp_done  = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept_0 || accept_1) state_nxt = EXEC;
         end
         EXEC: begin
            state_nxt = RESP;
         end
         RESP: begin
            rsp_done = op_grant ? bus.rsp_ready_1 : bus.rsp_ready_0;
            if (rsp_done) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         rr_ptr   <= RR_INIT;
         op_dir   <= 1'b0;
         op_amt   <= '0;
         op_data  <= '0;
         op_grant <= 1'b0;
         result   <= '0;
      end else begin
         if (accept_0 || accept_1) begin
            op_dir   <= accept_1 ? bus.req_dir_1 : bus.req_dir_0;
            op_amt   <= accept_1 ? bus.req_amt_1[4:0] : bus.req_amt_0[4:0];
            op_data  <= accept_1 ? bus.req_data_1 : bus.req_data_0;
            op_grant <= accept_1;
            rr_ptr   <= !accept_1;
         end
         if (state == EXEC) begin
            result <= rot_out;
         end
      end
   end

   assign bus.req_ready_0 = accept_0;
   assign bus.req_ready_1 = accept_1;
   assign bus.rsp_valid_0 = clear && (state == RESP) && !op_grant;
   assign bus.rsp_valid_1 = clear && (state == RESP) && op_grant;
   assign bus.rsp_data_0  = bus.rsp_valid_0 ? result : '0;
   assign bus.rsp_data_1  = bus.rsp_valid_1 ? result : '0;
   assign busy            = clear && (state != IDLE);
   assign grant_id        = busy && op_grant;

endmodule
